// File: rtl/serial_mul_param.sv
// Serial shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// One multiplier bit per RUN cycle; product register holds until the next completion.
module serial_mul_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic            r_mode;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_product;

    logic            w_last;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_sum;

    // Partial product and accumulator update; the signed MSB weight is negative, so it is subtracted.
    always_comb begin
        w_last = (r_count == CW'(WIDTH - 1));
        w_pp   = {PW{1'b0}};
        w_sum  = r_acc;
        if (r_mplier[0]) begin
            w_pp = r_mcand;
        end else begin
            w_pp = {PW{1'b0}};
        end
        if (r_mode && w_last) begin
            w_sum = r_acc - w_pp;
        end else begin
            w_sum = r_acc + w_pp;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Datapath: multiplicand shifts left and multiplier shifts right, so bit count of b meets a << count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode    <= 1'b0;
            r_mcand   <= {PW{1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_acc     <= {PW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_product <= {PW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_mcand  <= {{WIDTH{mode & a[WIDTH-1]}}, a};
                        r_mplier <= b;
                        r_acc    <= {PW{1'b0}};
                        r_count  <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= {r_mcand[PW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    if (w_last) begin
                        r_product <= w_sum;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_serial_mul_param.sv
// Directed self-checking bench for serial_mul_param at WIDTH=8 with hand-computed products.
module tb_serial_mul_param;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_total = 0;
    int n_pass  = 0;

    serial_mul_param #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation: accept, optional start poke mid-RUN with other operands, then latency/result/hold checks.
    task automatic do_mul(input string tag, input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp_p, input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        mode  = m;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end
            if (lat == 1) begin
                chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            end
            if (poke && lat == 3) begin
                start = 1'b1;
                a     = ~av;
                b     = 8'h5A;
                mode  = ~m;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, lat, W);
        chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp_p});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, {16'd0, product}, {16'd0, exp_p});
    endtask

    logic [2*W-1:0] hold_exp [3];
    int             hold_at  [3];

    initial begin
        int idx;
        int ndone;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", {16'd0, product}, 32'd0);
        rst = 1'b1;

        do_mul("u_ff_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        do_mul("s_fd_05",   1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
        do_mul("s_80_80",   1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
        do_mul("s_80_7f",   1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
        do_mul("u_ff_02",   1'b0, 8'hFF, 8'h02, 16'h01FE, 1'b0);
        do_mul("s_ff_02",   1'b1, 8'hFF, 8'h02, 16'hFFFE, 1'b0);
        do_mul("s_ff_ff",   1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
        do_mul("s_7f_7f",   1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);
        do_mul("u_00_ab",   1'b0, 8'h00, 8'hAB, 16'h0000, 1'b0);
        do_mul("u_poke",    1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);

        // start held high, operands change every cycle; accepts land on negedges 0, 10, 20.
        hold_exp[0] = 16'h0030; hold_at[0] = 9;
        hold_exp[1] = 16'h0256; hold_at[1] = 19;
        hold_exp[2] = 16'h060C; hold_at[2] = 29;
        ndone = 0;
        for (int n = 0; n < 31; n++) begin
            @(negedge clk);
            if (done) begin
                idx = (ndone < 3) ? ndone : 2;
                chk("hold_done_at", n, hold_at[idx]);
                chk("hold_prod", {16'd0, product}, {16'd0, hold_exp[idx]});
                ndone++;
            end
            mode  = 1'b0;
            a     = 8'h10 + 8'(n);
            b     = 8'h03 + 8'(2 * n);
            start = 1'b1;
        end
        start = 1'b0;
        chk("hold_ndone", ndone, 3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset while count==4: busy and product clear, no done afterwards.
        @(negedge clk);
        mode  = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_prod", {16'd0, product}, 32'd0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
            end
        end
        chk("mid_rst_nodone", ndone, 0);
        do_mul("after_rst", 1'b0, 8'h12, 8'h34, 16'h03A8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
